// File: rtl/nn_layer_seq.sv
// Time-multiplexed fully-connected layer: one MAC unit, run-time weight RAM,
// rescale / optional ReLU / saturation on each neuron result.
`timescale 1ns/1ps
module nn_layer_seq #(
   parameter  int unsigned N_IN   = 9,
   parameter  int unsigned N_OUT  = 9,
   parameter  int unsigned DATA_W = 32,
   parameter  int unsigned W_W    = 33,
   parameter  int unsigned SHIFT  = 26,
   parameter  int unsigned RELU   = 0,
   localparam int unsigned DEPTH  = N_OUT * N_IN,
   localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned IW     = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       w_we,
   input  logic [AW-1:0]              w_addr,
   input  logic signed [W_W-1:0]      w_data,
   input  logic                       start,
   input  logic [N_IN*DATA_W-1:0]     in_flat,
   output logic                       busy,
   output logic                       out_valid,
   output logic [IW-1:0]              out_idx,
   output logic signed [DATA_W-1:0]   out_data,
   output logic                       done
);

   localparam int unsigned KW    = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int unsigned PW    = DATA_W + W_W;
   localparam int unsigned ACC_W = PW + $clog2(N_IN);

   typedef enum logic [1:0] {IDLE, MAC, EMIT} state_t;

   state_t state, state_nxt;

   logic signed [W_W-1:0]    wmem   [DEPTH];
   logic signed [DATA_W-1:0] in_reg [N_IN];

   logic [KW-1:0]            k;
   logic [IW-1:0]            n;
   logic [AW-1:0]            rd_addr;
   logic signed [ACC_W-1:0]  acc;

   logic                     last_k, last_n;
   logic signed [PW-1:0]     prod;
   logic signed [ACC_W-1:0]  acc_sum;
   logic signed [ACC_W-1:0]  shifted;
   logic [ACC_W-DATA_W:0]    upper;
   logic signed [DATA_W-1:0] f_res;

   assign last_k = (k == KW'(N_IN - 1));
   assign last_n = (n == IW'(N_OUT - 1));

   // Weight RAM: no reset, writes only while idle and in range
   always_ff @(posedge clk) begin
      if (w_we && (state == IDLE) && (32'(w_addr) < DEPTH))
         wmem[w_addr] <= w_data;
   end

   // Input vector captured only on an accepted start
   always_ff @(posedge clk) begin
      if ((state == IDLE) && start) begin
         for (int i = 0; i < int'(N_IN); i++)
            in_reg[i] <= in_flat[i*DATA_W +: DATA_W];
      end
   end

   // Single MAC; rd_addr walks the RAM linearly so no n*N_IN multiply is needed
   always_comb begin
      prod    = PW'(in_reg[k]) * PW'(wmem[rd_addr]);
      acc_sum = acc + ACC_W'(prod);
   end

   // Output stage on the final sum: rescale, optional ReLU, saturate
   always_comb begin
      shifted = acc_sum >>> SHIFT;
      if ((RELU != 0) && shifted[ACC_W-1])
         shifted = '0;
      upper = shifted[ACC_W-1:DATA_W-1];
      if (!shifted[ACC_W-1] && (|upper))
         f_res = {1'b0, {(DATA_W-1){1'b1}}};
      else if (shifted[ACC_W-1] && !(&upper))
         f_res = {1'b1, {(DATA_W-1){1'b0}}};
      else
         f_res = shifted[DATA_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = MAC;
         MAC:     if (last_k) state_nxt = EMIT;
         EMIT:    state_nxt = last_n ? IDLE : MAC;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath and registered outputs; result is registered on the last MAC
   // edge so out_valid is high for exactly the EMIT cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         k         <= '0;
         n         <= '0;
         rd_addr   <= '0;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         out_idx   <= '0;
         out_data  <= '0;
      end else begin
         busy      <= (state_nxt != IDLE);
         out_valid <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  acc     <= '0;
                  k       <= '0;
                  n       <= '0;
                  rd_addr <= '0;
               end
            end
            MAC: begin
               acc     <= acc_sum;
               rd_addr <= rd_addr + AW'(1);
               if (last_k) begin
                  out_valid <= 1'b1;
                  out_idx   <= n;
                  out_data  <= f_res;
                  done      <= last_n;
               end else begin
                  k <= k + KW'(1);
               end
            end
            EMIT: begin
               acc <= '0;
               k   <= '0;
               if (!last_n) n <= n + IW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/nn_layer_seq.md
# nn_layer_seq

Parametrised, time-multiplexed fully-connected neural-network layer that generalises the fixed 9-input/9-neuron layers of the network to N_IN inputs and N_OUT neurons. It uses one multiply-accumulate unit and holds a run-time-writable weight RAM. The output stage applies a fixed-point rescale, an optional ReLU and saturation. Layers chain through a start/done handshake, with the output stream of one layer feeding the input bus of the next.

## Interface
- N_IN, default 9: inputs per neuron (≥1).
- N_OUT, default 9: neurons in the layer (≥1).
- DATA_W, default 32: signed width of layer inputs and outputs.
- W_W, default 33: signed weight width.
- SHIFT, default 26: arithmetic right shift applied to the accumulator (weight fractional bits).
- RELU, default 0: 1 = ReLU activation, 0 = linear.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- w_we  in  1  weight write strobe.
- w_addr  in  clog2(N_OUT*N_IN)  weight index = neuron*N_IN + input.
- w_data  in  W_W  signed weight value.
- start  in  1  begin one layer evaluation.
- in_flat  in  N_IN*DATA_W  input vector; element k is bits [k*DATA_W +: DATA_W].
- busy  out  1  high from accepted start until done.
- out_valid  out  1  one-cycle strobe per neuron result.
- out_idx  out  clog2(N_OUT)  neuron index of out_data.
- out_data  out  DATA_W  signed neuron result.
- done  out  1  one-cycle pulse at end of evaluation.

## Operation
- Storage:
  - Weight RAM: N_OUT*N_IN words of W_W bits. Not cleared by rst and not initialised by the block.
  - Input register: N_IN words of DATA_W bits, captured from in_flat on an accepted start.
- Weight writes:
  - On a cycle with w_we=1 and busy=0, weight[w_addr] takes w_data.
  - If busy=1, the write is ignored.
  - Writes to addresses ≥ N_OUT*N_IN are ignored.
- FSM states are IDLE, MAC and EMIT.
  - IDLE: when start=1, capture in_flat, clear acc, set n=0 and k=0, then go to MAC. A start while not in IDLE is ignored.
  - MAC: each cycle, acc += input[k]*weight[n*N_IN+k] and k increments. After the k=N_IN-1 term, go to EMIT.
  - EMIT:
    - Drive out_valid=1, out_idx=n and out_data=f(acc).
    - Clear acc and set k=0.
    - If n=N_OUT-1, assert done=1 and return to IDLE.
    - Otherwise increment n and return to MAC.
- Arithmetic:
  - Each product is full-precision and signed, DATA_W+W_W bits.
  - acc is DATA_W+W_W+clog2(N_IN) bits and never overflows.
  - f(acc): shift acc right arithmetically by SHIFT; if RELU=1, replace negative values with 0; then saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- busy = (state != IDLE).

## Timing
- Reset values: busy=0, out_valid=0, done=0, out_idx=0, out_data=0. State=IDLE, counters=0, acc=0.
- rst=1 mid-evaluation aborts it on that edge:
  - No further out_valid or done is produced.
  - Weights are preserved.
- Start accepted at edge T:
  - busy=1 from T+1.
  - Results for neuron n are presented during cycle T+1+(n+1)·N_IN+n.
  - done coincides with the out_valid for neuron N_OUT-1.
  - busy=0 in the cycle after done.
  - Total evaluation time N_OUT·(N_IN+1) cycles.
- out_data and out_idx hold their last values between strobes. A downstream consumer may only sample them while out_valid=1.
- start held high continuously: the next evaluation is accepted on the first IDLE cycle, giving one idle cycle between runs.
- start and w_we in the same IDLE cycle: both are accepted, and the write lands before the first MAC read.
- in_flat is ignored except at the accepted start edge.
- Edge case N_IN=1: each neuron takes 1 MAC cycle plus 1 EMIT cycle.

## Test plan
- Reset and idle: hold rst for 3 cycles, then idle for 20 cycles with no start.
  - All outputs stay 0 and busy=0.
- Basic run: N_IN=3, N_OUT=2, SHIFT=0, RELU=0.
  - Weights {1,2,3} and {-1,0,4}; inputs {5,6,7}.
  - out_valid with idx0=38 at T+4 and idx1=23 at T+8, done at T+8.
- ReLU and rescale: SHIFT=2, RELU=1, neuron sums -40 and 41.
  - Outputs 0 and 10 (41>>>2).
- Saturation: DATA_W=8, SHIFT=0, inputs 127, weights 127.
  - out_data=127.
  - Negating one operand gives -128.
- Protection:
  - w_we pulses while busy leave results unchanged.
  - A start pulse mid-run is ignored: exactly N_OUT out_valid strobes and one done.
- Reset mid-operation: rst at the 5th MAC cycle.
  - No out_valid or done follows.
  - A restart without reloading weights reproduces the basic-run results.
